mario_motion: RTL

MARIO_MOTION -- requirements
Module: mario_motion

---
 rtl/mario_motion.sv | 284 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mario_motion.sv
// Per-frame Mario position update with tile collision against the background map.
// Defining MARIO_DOUBLE_JUMP_EN adds a single mid-air jump credit, restored on landing.
module mario_motion #(
    parameter int BDR           = 0,
    parameter int BLK           = 2,
    parameter int GND           = 3,
    parameter int MARIO_WIDTH   = 42,
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int BLOCK_WIDTH   = 40,
    parameter int WALK_SPEED    = 2,
    parameter int JUMP_VELOCITY = 12,
    parameter int GRAVITY       = 1,
    parameter int MAX_FALL      = 8,
    parameter int START_X       = 40,
    parameter int START_Y       = 358
) (
    input  logic vga_clock,
    input  logic reset,
    input  logic frame_tick,
    input  logic btn_left,
    input  logic btn_right,
    input  logic btn_jump,
    input  byte  background [11:0][16:0],
    output int   mario_x,
    output int   mario_y,
    output logic airborne,
    output logic busy
);

    typedef enum logic [2:0] {
        IDLE,
        HMOVE,
        HCHK,
        VMOVE,
        VCHK,
        COMMIT
    } state_t;

    localparam int X_MAX = SCREEN_WIDTH - MARIO_WIDTH;
    localparam int Y_MAX = SCREEN_HEIGHT - MARIO_WIDTH;

    state_t state;
    state_t state_next;

    logic left_s;
    logic right_s;
    logic jump_s;
    logic jump_hist;

    logic signed [7:0] vy;
    logic signed [7:0] cand_vy;
    logic              grounded;
    logic              cand_grounded;
    int                cand_x;
    int                cand_y;

    int                dx;
    int                hmove_x;
    int                lead_x;
    int                hchk_x;

    logic              jump_edge;
    int                fall_vy;
    logic signed [7:0] vm_vy;
    logic              vm_grounded;
    int                vm_y;

    logic signed [7:0] vc_vy;
    logic              vc_grounded;
    int                vc_y;
    int                feet_y;
    int                right_x;

`ifdef MARIO_DOUBLE_JUMP_EN
    logic credit;
    logic cand_credit;
    logic vm_credit;
    logic vc_credit;
`endif

    // Anything off the 12x16 visible map counts as solid, as do negative coordinates.
    function automatic logic solid_at(input int px, input int py);
        logic [3:0] r;
        logic [4:0] c;
        byte        code;
        logic       s;
        r    = '0;
        c    = '0;
        code = 8'sd0;
        if (px < 0 || py < 0 || (px / BLOCK_WIDTH) > 15 || (py / BLOCK_WIDTH) > 11) begin
            s = 1'b1;
        end else begin
            r    = 4'(py / BLOCK_WIDTH);
            c    = 5'(px / BLOCK_WIDTH);
            code = background[r][c];
            s    = (int'(code) == BDR) || (int'(code) == BLK) || (int'(code) == GND);
        end
        return s;
    endfunction

    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (frame_tick) state_next = HMOVE;
            HMOVE:   state_next = HCHK;
            HCHK:    state_next = VMOVE;
            VMOVE:   state_next = VCHK;
            VCHK:    state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Horizontal step, then revert if the leading edge would enter a solid tile.
    always_comb begin
        dx = 0;
        if (left_s && !right_s) begin
            dx = -WALK_SPEED;
        end else if (right_s && !left_s) begin
            dx = WALK_SPEED;
        end

        hmove_x = mario_x + dx;
        if (hmove_x < 0) begin
            hmove_x = 0;
        end else if (hmove_x > X_MAX) begin
            hmove_x = X_MAX;
        end

        lead_x = (dx > 0) ? cand_x + MARIO_WIDTH - 1 : cand_x;
        hchk_x = cand_x;
        if (dx != 0 && (solid_at(lead_x, mario_y) ||
                        solid_at(lead_x, mario_y + MARIO_WIDTH - 1))) begin
            hchk_x = mario_x;
        end
    end

    always_comb begin
        jump_edge   = jump_s && !jump_hist;
        fall_vy     = int'(vy) + GRAVITY;
        if (fall_vy > MAX_FALL) begin
            fall_vy = MAX_FALL;
        end
        vm_vy       = vy;
        vm_grounded = grounded;
`ifdef MARIO_DOUBLE_JUMP_EN
        vm_credit   = credit;
`endif
        if (jump_edge && grounded) begin
            vm_vy       = 8'(-JUMP_VELOCITY);
            vm_grounded = 1'b0;
        end
`ifdef MARIO_DOUBLE_JUMP_EN
        else if (jump_edge && credit) begin
            vm_vy     = 8'(-JUMP_VELOCITY);
            vm_credit = 1'b0;
        end
`endif
        else if (!grounded) begin
            vm_vy = 8'(fall_vy);
        end
        vm_y = mario_y + int'(vm_vy);
    end

    // Vertical resolution: land on the row below the feet, bump the head, or
    // start falling when walking off an edge; screen clamps apply last.
    always_comb begin
        vc_y        = cand_y;
        vc_vy       = cand_vy;
        vc_grounded = cand_grounded;
`ifdef MARIO_DOUBLE_JUMP_EN
        vc_credit   = cand_credit;
`endif
        feet_y      = cand_y + MARIO_WIDTH;
        right_x     = cand_x + MARIO_WIDTH - 1;

        if (cand_vy > 8'sd0) begin
            if (solid_at(cand_x, feet_y) || solid_at(right_x, feet_y)) begin
                vc_y        = (feet_y / BLOCK_WIDTH) * BLOCK_WIDTH - MARIO_WIDTH;
                vc_vy       = 8'sd0;
                vc_grounded = 1'b1;
`ifdef MARIO_DOUBLE_JUMP_EN
                vc_credit   = 1'b1;
`endif
            end
        end else if (cand_vy < 8'sd0) begin
            if (cand_y >= 0 && (solid_at(cand_x, cand_y) || solid_at(right_x, cand_y))) begin
                vc_y  = (cand_y / BLOCK_WIDTH + 1) * BLOCK_WIDTH;
                vc_vy = 8'sd0;
            end
        end else begin
            if (!solid_at(cand_x, feet_y) && !solid_at(right_x, feet_y)) begin
                vc_grounded = 1'b0;
            end
        end

        if (vc_y < 0) begin
            vc_y  = 0;
            vc_vy = 8'sd0;
        end else if (vc_y > Y_MAX) begin
            vc_y        = Y_MAX;
            vc_vy       = 8'sd0;
            vc_grounded = 1'b1;
`ifdef MARIO_DOUBLE_JUMP_EN
            vc_credit   = 1'b1;
`endif
        end
    end

    // Candidates walk through the pipeline; visible state changes only in COMMIT.
    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            left_s        <= 1'b0;
            right_s       <= 1'b0;
            jump_s        <= 1'b0;
            jump_hist     <= 1'b0;
            cand_x        <= START_X;
            cand_y        <= START_Y;
            cand_vy       <= 8'sd0;
            cand_grounded <= 1'b1;
            mario_x       <= START_X;
            mario_y       <= START_Y;
            vy            <= 8'sd0;
            grounded      <= 1'b1;
            airborne      <= 1'b0;
`ifdef MARIO_DOUBLE_JUMP_EN
            credit        <= 1'b1;
            cand_credit   <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (frame_tick) begin
                        left_s  <= btn_left;
                        right_s <= btn_right;
                        jump_s  <= btn_jump;
                    end
                end
                HMOVE: cand_x <= hmove_x;
                HCHK:  cand_x <= hchk_x;
                VMOVE: begin
                    cand_y        <= vm_y;
                    cand_vy       <= vm_vy;
                    cand_grounded <= vm_grounded;
`ifdef MARIO_DOUBLE_JUMP_EN
                    cand_credit   <= vm_credit;
`endif
                end
                VCHK: begin
                    cand_y        <= vc_y;
                    cand_vy       <= vc_vy;
                    cand_grounded <= vc_grounded;
`ifdef MARIO_DOUBLE_JUMP_EN
                    cand_credit   <= vc_credit;
`endif
                end
                COMMIT: begin
                    mario_x   <= cand_x;
                    mario_y   <= cand_y;
                    vy        <= cand_vy;
                    grounded  <= cand_grounded;
                    airborne  <= !cand_grounded;
                    jump_hist <= jump_s;
`ifdef MARIO_DOUBLE_JUMP_EN
                    credit    <= cand_credit;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
